// File: rtl/bicubic_pkg.sv
// Shared widths, coefficient types and the phase-indexed 2D bicubic weight table
// (Keys kernel, a = -0.5) used by the 16X bicubic DSP accumulator.
package bicubic_pkg;

  localparam int unsigned TAP_NUM = 16;
  localparam int unsigned COEF_W  = 18;
  localparam int unsigned FRAC_W  = 16;
  localparam int unsigned PROD_W  = 27;
  localparam int unsigned PSUM_W  = 29;
  localparam int unsigned SUM_W   = 31;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t     [TAP_NUM-1:0] coef_vec_t;
  typedef coef_vec_t [3:0]         coef_phx_t;
  typedef coef_phx_t [1:0]         coef_tab_t;

  // 1D kernel weight in 1/1024 units at offset t = t8/8 for tap column c (0..3).
  function automatic int kern_1d(input int t8, input logic [1:0] c);
    int t2;
    int t3;
    t2 = t8 * t8;
    t3 = t2 * t8;
    case (c)
      2'd0:    return -t3 + 16 * t2 - 64 * t8;
      2'd1:    return 3 * t3 - 40 * t2 + 1024;
      2'd2:    return -3 * t3 + 32 * t2 + 64 * t8;
      default: return t3 - 8 * t2;
    endcase
  endfunction

  // Tap k sits at row k/4, column k%4. phase_y selects ty = 1/8 or 3/8 (the mux
  // mirrors the other half), phase_x selects tx = 1/8, 3/8, 5/8, 7/8.
  // Each entry is rounded half away from zero; the rounding residual goes to the
  // largest weight so every phase sums to exactly 1.0 in Q16.
  function automatic coef_tab_t build_w2d();
    coef_tab_t   tab;
    int          w [TAP_NUM];
    int          p;
    int          acc;
    logic [3:0]  imax;
    tab = '0;
    for (int unsigned py = 0; py < 2; py++) begin
      for (int unsigned px = 0; px < 4; px++) begin
        acc  = 0;
        imax = '0;
        for (int unsigned k = 0; k < TAP_NUM; k++) begin
          p    = kern_1d(int'(2 * py + 1), k[3:2]) * kern_1d(int'(2 * px + 1), k[1:0]);
          w[k] = (p >= 0) ? (p + 8) / 16 : -((8 - p) / 16);
          acc  = acc + w[k];
          if (w[k] > w[imax]) imax = k[3:0];
        end
        w[imax] = w[imax] + (1 << FRAC_W) - acc;
        for (int unsigned k = 0; k < TAP_NUM; k++) begin
          tab[py[0]][px[1:0]][k[3:0]] = coef_t'(w[k]);
        end
      end
    end
    return tab;
  endfunction

  localparam coef_tab_t BICUBIC_W2D = build_w2d();

endpackage

// File: rtl/bicubic_round_clip.sv
// Final-stage round-to-nearest of the Q16 accumulator and clip to an 8-bit pixel,
// flagging any output that had to be saturated.
module bicubic_round_clip
  import bicubic_pkg::*;
(
  input  logic signed [SUM_W-1:0] sum_in,
  output logic        [7:0]       px,
  output logic                    clip
);

  localparam logic signed [SUM_W:0] HALF = (SUM_W + 1)'(1 << (FRAC_W - 1));

  logic signed [SUM_W:0] biased;
  logic signed [SUM_W:0] r;

  always_comb begin
    biased = $signed({sum_in[SUM_W-1], sum_in}) + HALF;
    r      = biased >>> FRAC_W;
    px     = r[7:0];
    clip   = 1'b0;
    if (r < 0) begin
      px   = '0;
      clip = 1'b1;
    end else if (r > 255) begin
      px   = '1;
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/bicubic_dsp_accum.sv
// Four-stage bicubic multiply-accumulate: 16 weighted taps -> partial sums ->
// total -> rounded/clipped pixel, with a saturating clip-event counter.
module bicubic_dsp_accum
  import bicubic_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = 4,
  parameter int unsigned CLIP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  clken,
  input  logic                  valid_in,
  input  logic [63:0]           dsp_grp_l_in,
  input  logic [63:0]           dsp_grp_h_in,
  input  logic [1:0]            phase_x,
  input  logic                  phase_y,
  input  logic                  clip_clr,
  output logic [7:0]            px_out,
  output logic                  valid_out,
  output logic [CLIP_CNT_W-1:0] clip_cnt
);

  if (PIPE_LAT != 4) begin : g_bad_pipe_lat
    $error("bicubic_dsp_accum: PIPE_LAT is fixed at 4");
  end

  logic signed [PROD_W-1:0] p_d    [TAP_NUM];
  logic signed [PROD_W-1:0] p_q    [TAP_NUM];
  logic signed [PSUM_W-1:0] psum_d [4];
  logic signed [PSUM_W-1:0] psum_q [4];
  logic signed [SUM_W-1:0]  sum_d, sum_q;
  logic                     v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [7:0]               px_out_d, px_out_q;
  logic                     valid_out_d, valid_out_q;
  logic [CLIP_CNT_W-1:0]    clip_cnt_d, clip_cnt_q;

  coef_vec_t  coef;
  logic [7:0] tap [TAP_NUM];
  logic [7:0] px_rc;
  logic       clip_rc;

  // S1: weights are picked from the phase presented alongside valid_in.
  always_comb begin
    coef = BICUBIC_W2D[phase_y][phase_x];
    for (int unsigned k = 0; k < TAP_NUM / 2; k++) begin
      tap[k]               = dsp_grp_l_in[8*k +: 8];
      tap[k + TAP_NUM / 2] = dsp_grp_h_in[8*k +: 8];
    end
    for (int unsigned k = 0; k < TAP_NUM; k++) begin
      p_d[k] = PROD_W'(signed'({1'b0, tap[k]})) * PROD_W'($signed(coef[k]));
    end
    v1_d = valid_in;
  end

  always_comb begin
    for (int unsigned j = 0; j < 4; j++) begin
      psum_d[j] = PSUM_W'(p_q[4*j])     + PSUM_W'(p_q[4*j + 1])
                + PSUM_W'(p_q[4*j + 2]) + PSUM_W'(p_q[4*j + 3]);
    end
    v2_d  = v1_q;
    sum_d = SUM_W'(psum_q[0]) + SUM_W'(psum_q[1]) + SUM_W'(psum_q[2]) + SUM_W'(psum_q[3]);
    v3_d  = v2_q;
  end

  bicubic_round_clip u_round_clip (
    .sum_in (sum_q),
    .px     (px_rc),
    .clip   (clip_rc)
  );

  // A clear in the same enabled cycle as a clip event takes priority.
  always_comb begin
    valid_out_d = v3_q;
    px_out_d    = v3_q ? px_rc : px_out_q;
    clip_cnt_d  = clip_cnt_q;
    if (clip_clr) begin
      clip_cnt_d = '0;
    end else if (v3_q && clip_rc && (clip_cnt_q != '1)) begin
      clip_cnt_d = clip_cnt_q + CLIP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned k = 0; k < TAP_NUM; k++) p_q[k] <= '0;
      for (int unsigned j = 0; j < 4; j++) psum_q[j] <= '0;
      sum_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      px_out_q    <= '0;
      valid_out_q <= 1'b0;
      clip_cnt_q  <= '0;
    end else if (clken) begin
      for (int unsigned k = 0; k < TAP_NUM; k++) p_q[k] <= p_d[k];
      for (int unsigned j = 0; j < 4; j++) psum_q[j] <= psum_d[j];
      sum_q       <= sum_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      px_out_q    <= px_out_d;
      valid_out_q <= valid_out_d;
      clip_cnt_q  <= clip_cnt_d;
    end
  end

  assign px_out    = px_out_q;
  assign valid_out = valid_out_q;
  assign clip_cnt  = clip_cnt_q;

endmodule

// File: tb/tb_bicubic_dsp_accum.sv
// Bench for bicubic_dsp_accum: constant vector table, corner-case sequences and
// random traffic checked against a Keys-kernel model with a latency scoreboard.
module tb_bicubic_dsp_accum;

  logic        clk = 1'b0;
  logic        aresetn, clken, valid_in, phase_y, clip_clr;
  logic [63:0] dsp_grp_l_in, dsp_grp_h_in;
  logic [1:0]  phase_x;
  logic [7:0]  px_out;
  logic        valid_out;
  logic [15:0] clip_cnt;

  always #5 clk = ~clk;

  bicubic_dsp_accum #(.PIPE_LAT(4), .CLIP_CNT_W(16)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .clken        (clken),
    .valid_in     (valid_in),
    .dsp_grp_l_in (dsp_grp_l_in),
    .dsp_grp_h_in (dsp_grp_h_in),
    .phase_x      (phase_x),
    .phase_y      (phase_y),
    .clip_clr     (clip_clr),
    .px_out       (px_out),
    .valid_out    (valid_out),
    .clip_cnt     (clip_cnt)
  );

  localparam logic [63:0] FLAT100 = 64'h6464646464646464;
  localparam logic [63:0] STEP_UP = 64'hFFFFFF00_FFFFFF00; // column 0 dark, 1..3 bright
  localparam logic [63:0] STEP_DN = 64'h000000FF_000000FF; // column 0 bright, 1..3 dark

  typedef struct {
    logic [63:0] l;
    logic [63:0] h;
    int          px;
    int          py;
    int          exp_px;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  int          ref_w [2][4][16];
  int unsigned en_cnt = 0;
  int          q_val [$];
  bit          q_clip [$];
  int unsigned q_due [$];
  int          exp_px    = 0;
  int          exp_valid = 0;
  int          exp_cnt   = 0;
  int          obs_cnt   = 0;
  int          obs_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic real keys(input real x);
    real ax;
    ax = (x < 0.0) ? -x : x;
    if (ax <= 1.0) return 1.5 * ax * ax * ax - 2.5 * ax * ax + 1.0;
    if (ax < 2.0)  return -0.5 * ax * ax * ax + 2.5 * ax * ax - 4.0 * ax + 2.0;
    return 0.0;
  endfunction

  task automatic init_ref();
    real ty, tx, v;
    int  acc, imax;
    for (int py = 0; py < 2; py++) begin
      for (int px = 0; px < 4; px++) begin
        ty = (2.0 * py + 1.0) / 8.0;
        tx = (2.0 * px + 1.0) / 8.0;
        acc = 0;
        imax = 0;
        for (int k = 0; k < 16; k++) begin
          v = keys(ty - real'(k / 4 - 1)) * keys(tx - real'(k % 4 - 1)) * 65536.0;
          ref_w[py][px][k] = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
          acc += ref_w[py][px][k];
          if (ref_w[py][px][k] > ref_w[py][px][imax]) imax = k;
        end
        ref_w[py][px][imax] += 65536 - acc;
      end
    end
  endtask

  task automatic ref_pixel(input logic [63:0] l, input logic [63:0] h, input int px,
                           input int py, output int val, output bit clp);
    longint acc;
    longint r;
    int     t;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      t = (k < 8) ? int'(l[8*k +: 8]) : int'(h[8*(k-8) +: 8]);
      acc += longint'(t) * longint'(ref_w[py][px][k]);
    end
    r = (acc + 32768) >>> 16;
    clp = (r < 0) || (r > 255);
    val = (r < 0) ? 0 : (r > 255) ? 255 : int'(r);
  endtask

  task automatic model_reset();
    q_val.delete();
    q_clip.delete();
    q_due.delete();
    exp_px    = 0;
    exp_valid = 0;
    exp_cnt   = 0;
  endtask

  function automatic logic [63:0] rand_taps();
    logic [63:0] v;
    for (int b = 0; b < 8; b++) begin
      if ($urandom_range(2) == 0) v[8*b +: 8] = ($urandom_range(1) == 1) ? 8'hFF : 8'h00;
      else                        v[8*b +: 8] = 8'($urandom);
    end
    return v;
  endfunction

  // One clock: drive, advance the model on the edge, then compare all outputs.
  task automatic cyc(input bit en, input bit vin, input logic [63:0] l, input logic [63:0] h,
                     input int px, input int py, input bit clr);
    int val, pv;
    bit clp, pc, popped;
    clken        = en;
    valid_in     = vin;
    dsp_grp_l_in = l;
    dsp_grp_h_in = h;
    phase_x      = px[1:0];
    phase_y      = py[0];
    clip_clr     = clr;
    @(posedge clk);
    if (aresetn && en) begin
      en_cnt++;
      popped = 0;
      pv = 0;
      pc = 0;
      if (q_due.size() > 0 && q_due[0] == en_cnt) begin
        popped = 1;
        pv = q_val.pop_front();
        pc = q_clip.pop_front();
        void'(q_due.pop_front());
      end
      if (vin) begin
        ref_pixel(l, h, px, py, val, clp);
        q_val.push_back(val);
        q_clip.push_back(clp);
        q_due.push_back(en_cnt + 3);
      end
      exp_valid = int'(popped);
      if (popped) exp_px = pv;
      if (clr) exp_cnt = 0;
      else if (popped && pc && exp_cnt < 65535) exp_cnt++;
    end
    #1;
    if (aresetn && en && valid_out) begin
      obs_cnt++;
      obs_q.push_back(int'(px_out));
    end
    chk("valid_out", int'(valid_out), exp_valid);
    chk("px_out", int'(px_out), exp_px);
    chk("clip_cnt", int'(clip_cnt), exp_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, rand_taps(), rand_taps(), $urandom_range(3), $urandom_range(1), 1'b0);
  endtask

  initial begin
    vec_t        tab [12];
    int          exp_list [$];
    logic [63:0] l, h;
    int          px, py, v, obs_before;
    bit          c;

    init_ref();
    for (int i = 0; i < 8; i++) tab[i] = '{FLAT100, FLAT100, i % 4, i / 4, 100};
    tab[8]  = '{64'h0, 64'h0, 2, 1, 0};
    tab[9]  = '{'1, '1, 1, 0, 255};
    tab[10] = '{STEP_UP, STEP_UP, 0, 1, 255};
    tab[11] = '{STEP_DN, STEP_DN, 1, 1, 0};

    aresetn = 1'b0; clken = 1'b0; valid_in = 1'b0; clip_clr = 1'b0;
    dsp_grp_l_in = '0; dsp_grp_h_in = '0; phase_x = '0; phase_y = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("reset px_out", int'(px_out), 0);
    chk("reset valid_out", int'(valid_out), 0);
    chk("reset clip_cnt", int'(clip_cnt), 0);
    aresetn = 1'b1;
    idle(2);

    // Overshoot then undershoot, each clipped.
    cyc(1'b1, 1'b1, STEP_UP, STEP_UP, 0, 0, 1'b0);
    idle(3);
    chk("overshoot px_out", int'(px_out), 255);
    chk("overshoot valid_out", int'(valid_out), 1);
    chk("overshoot clip_cnt", int'(clip_cnt), 1);
    cyc(1'b1, 1'b1, STEP_DN, STEP_DN, 0, 0, 1'b0);
    idle(3);
    chk("undershoot px_out", int'(px_out), 0);
    chk("undershoot clip_cnt", int'(clip_cnt), 2);

    foreach (tab[i]) begin
      cyc(1'b1, 1'b1, tab[i].l, tab[i].h, tab[i].px, tab[i].py, 1'b0);
      idle(3);
      chk($sformatf("vec%0d px_out", i), int'(px_out), tab[i].exp_px);
      chk($sformatf("vec%0d valid_out", i), int'(valid_out), 1);
    end

    // 20 back-to-back inputs with a 3-cycle stall in the middle.
    obs_cnt = 0;
    obs_q.delete();
    for (int i = 0; i < 20; i++) begin
      l = rand_taps(); h = rand_taps();
      px = $urandom_range(3); py = $urandom_range(1);
      ref_pixel(l, h, px, py, v, c);
      exp_list.push_back(v);
      if (i == 10) repeat (3) cyc(1'b0, 1'b1, l, h, px, py, 1'b0);
      cyc(1'b1, 1'b1, l, h, px, py, 1'b0);
    end
    idle(4);
    chk("stream output count", obs_cnt, 20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("stream[%0d]", i), (i < obs_q.size()) ? obs_q[i] : -1, exp_list[i]);

    for (int i = 0; i < 300; i++)
      cyc($urandom_range(99) < 85, $urandom_range(99) < 70, rand_taps(), rand_taps(),
          $urandom_range(3), $urandom_range(1), $urandom_range(99) < 3);

    // Reset with three results in flight.
    cyc(1'b1, 1'b1, FLAT100, FLAT100, 2, 0, 1'b0);
    idle(3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, rand_taps(), rand_taps(), 3, 1, 1'b0);
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("async reset px_out", int'(px_out), 0);
    chk("async reset valid_out", int'(valid_out), 0);
    idle(2);
    aresetn = 1'b1;
    obs_before = obs_cnt;
    idle(6);
    chk("no stale outputs after reset", obs_cnt - obs_before, 0);

    // Saturate the clip counter, then clear it on a clipping output.
    for (int i = 0; i < 65540; i++) cyc(1'b1, 1'b1, STEP_UP, STEP_UP, 0, 0, 1'b0);
    idle(3);
    chk("clip_cnt saturated", int'(clip_cnt), 65535);
    cyc(1'b0, 1'b0, STEP_UP, STEP_UP, 0, 0, 1'b1);
    chk("clip_clr ignored while stalled", int'(clip_cnt), 65535);
    cyc(1'b1, 1'b1, STEP_UP, STEP_UP, 0, 0, 1'b0);
    idle(2);
    cyc(1'b1, 1'b0, '0, '0, 0, 0, 1'b1);
    chk("clear beats increment", int'(clip_cnt), 0);
    chk("clear cycle valid_out", int'(valid_out), 1);
    chk("clear cycle px_out", int'(px_out), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
